// File: rtl/apb_master_if.sv
// Bundle of the command stream, response stream and APB4 bus around apb_master.
//
// Handshake rule for the cmd_* and rsp_* channels: a beat moves on the rising
// clock edge where valid and ready are both high. Once valid is raised, the
// source holds it and its payload steady until that edge. ready may rise or
// fall at any time and never waits for valid.
interface apb_master_if #(
    parameter int AWIDTH = 10,
    parameter int DSIZE  = 2
) ();
    localparam int DBYTES = 1 << DSIZE;
    localparam int DWIDTH = DBYTES * 8;

    // command stream
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DBYTES-1:0] cmd_strb;
    logic [DWIDTH-1:0] cmd_wdata;
    logic [2:0]        cmd_prot;

    // response stream
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    // APB4 bus
    logic              psel;
    logic              penable;
    logic [2:0]        pprot;
    logic              pwrite;
    logic [AWIDTH-1:0] paddr;
    logic [DBYTES-1:0] pstrb;
    logic [DWIDTH-1:0] pwdata;
    logic [DWIDTH-1:0] prdata;
    logic              pready;
    logic              pslverr;

    // FSM state: 0 IDLE, 1 SETUP, 2 ACCESS, 3 RESP
    logic [1:0]        dbg_state;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_strb, cmd_wdata, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output psel, penable, pprot, pwrite, paddr, pstrb, pwdata,
        input  prdata, pready, pslverr,
        output dbg_state
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_strb, cmd_wdata, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  psel, penable, pprot, pwrite, paddr, pstrb, pwdata,
        output prdata, pready, pslverr,
        input  dbg_state
    );
endinterface

// File: rtl/apb_master.sv
// APB4 requester: turns each accepted command into one APB transfer and
// returns one response. A wait-state counter aborts a transfer whose slave
// never raises pready.
module apb_master #(
    parameter int AWIDTH  = 10,
    parameter int DSIZE   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic         pclk,
    input  logic         preset,
    apb_master_if.master bus
);
    localparam int DBYTES = 1 << DSIZE;
    localparam int DWIDTH = DBYTES * 8;
    localparam int CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e            state_q,       state_d;
    logic              psel_q,        psel_d;
    logic              penable_q,     penable_d;
    logic              pwrite_q,      pwrite_d;
    logic [AWIDTH-1:0] paddr_q,       paddr_d;
    logic [DBYTES-1:0] pstrb_q,       pstrb_d;
    logic [DWIDTH-1:0] pwdata_q,      pwdata_d;
    logic [2:0]        pprot_q,       pprot_d;
    logic [DWIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
    logic              rsp_err_q,     rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]     cnt_q,         cnt_d;
    logic [CW-1:0]     cnt_inc;

    // State register and all registered outputs; reset clears everything.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pstrb_q       <= '0;
            pwdata_q      <= '0;
            pprot_q       <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pstrb_q       <= pstrb_d;
            pwdata_q      <= pwdata_d;
            pprot_q       <= pprot_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pstrb_d       = pstrb_q;
        pwdata_d      = pwdata_q;
        pprot_d       = pprot_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        cnt_d         = cnt_q;
        // saturating increment so a disabled timeout never wraps
        cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    // reads carry no data and no strobes on the bus
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pstrb_d  = bus.cmd_write ? bus.cmd_strb  : '0;
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    pprot_d  = bus.cmd_prot;
                    psel_d   = 1'b1;
                    penable_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    // pready wins over a timeout landing on the same cycle
                    rsp_err_d     = bus.pslverr;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
                    rsp_timeout_d = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if ((TIMEOUT != 0) && (cnt_inc == TO_VAL)) begin
                        rsp_err_d     = 1'b1;
                        rsp_rdata_d   = '0;
                        rsp_timeout_d = 1'b1;
                        psel_d        = 1'b0;
                        penable_d     = 1'b0;
                        state_d       = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready   = (state_q == IDLE) && !preset;
    assign bus.rsp_valid   = (state_q == RESP);
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pprot       = pprot_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pstrb       = pstrb_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: a table of single transfers with their expected APB
// timing and responses, plus hand sequences for back-to-back traffic and
// reset in the middle of a transfer.
module tb_apb_master;
    localparam int AW = 10;
    localparam int DS = 2;
    localparam int TO = 16;

    logic pclk;
    logic preset;

    apb_master_if #(.AWIDTH(AW), .DSIZE(DS)) bus ();

    apb_master #(.AWIDTH(AW), .DSIZE(DS), .TIMEOUT(TO)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus.master)
    );

    typedef struct {
        logic        write;
        logic [9:0]  addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [2:0]  prot;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
        int          hold;
        int          exp_acc;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
    } vec_t;

    vec_t        vecs[8];
    logic [33:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] slave_data(input logic [9:0] a);
        return 32'hA5A50000 | {22'h0, a};
    endfunction

    task automatic check_bus(input vec_t v, input logic [3:0] e_strb, input logic [31:0] e_wdata);
        check("paddr",  bus.paddr,  v.addr);
        check("pwrite", bus.pwrite, v.write);
        check("pstrb",  bus.pstrb,  e_strb);
        check("pwdata", bus.pwdata, e_wdata);
        check("pprot",  bus.pprot,  v.prot);
    endtask

    task automatic sb_pop(input string name);
        logic [33:0] exp;
        if (exp_q.size() == 0) begin
            check({name, "_unexpected"}, 1'b1, 1'b0);
        end else begin
            exp = exp_q.pop_front();
            check(name, {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, exp);
        end
    endtask

    // driver: one command through a scripted slave
    task automatic run_xfer(input vec_t v);
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        int          acc;
        e_strb  = v.write ? v.strb  : 4'h0;
        e_wdata = v.write ? v.wdata : 32'h0;
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.write;
        bus.cmd_addr  = v.addr;
        bus.cmd_strb  = v.strb;
        bus.cmd_wdata = v.wdata;
        bus.cmd_prot  = v.prot;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        check("cmd_ready_idle", bus.cmd_ready, 1'b1);
        check("psel_idle", bus.psel, 1'b0);
        exp_q.push_back({v.exp_rdata, v.exp_err, v.exp_to});
        // SETUP cycle; scramble the command inputs to prove they are ignored
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        bus.cmd_write = ~v.write;
        bus.cmd_addr  = 10'($urandom);
        bus.cmd_strb  = 4'($urandom);
        bus.cmd_wdata = $urandom;
        bus.cmd_prot  = 3'($urandom);
        check("psel_setup", bus.psel, 1'b1);
        check("penable_setup", bus.penable, 1'b0);
        check("cmd_ready_busy", bus.cmd_ready, 1'b0);
        check_bus(v, e_strb, e_wdata);
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge pclk);
            if (bus.penable !== 1'b1) break;
            acc++;
            check("psel_access", bus.psel, 1'b1);
            check_bus(v, e_strb, e_wdata);
            if (acc > v.waits) begin
                bus.pready  = 1'b1;
                bus.prdata  = v.rdata;
                bus.pslverr = v.slverr;
            end else begin
                bus.pready  = 1'b0;
                bus.prdata  = $urandom;
                bus.pslverr = 1'($urandom_range(0, 1));
            end
        end
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;
        check("access_cycles", acc, v.exp_acc);
        // a command offered during RESP must not be taken
        bus.cmd_valid = (v.hold > 0);
        for (int h = 0; h < v.hold; h++) begin
            check("rsp_valid_hold", bus.rsp_valid, 1'b1);
            check("cmd_ready_resp", bus.cmd_ready, 1'b0);
            check("psel_resp_hold", bus.psel, 1'b0);
            if (exp_q.size() > 0)
                check("rsp_stable", {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, exp_q[0]);
            @(negedge pclk);
        end
        check("rsp_valid", bus.rsp_valid, 1'b1);
        check("psel_resp", bus.psel, 1'b0);
        check("penable_resp", bus.penable, 1'b0);
        sb_pop("rsp");
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check("rsp_done", bus.rsp_valid, 1'b0);
        check("psel_after", bus.psel, 1'b0);
        check("state_idle", bus.dbg_state, 2'd0);
    endtask

    // driver: four commands with cmd_valid and rsp_ready held high
    task automatic back_to_back();
        int  last_acc;
        int  n_acc;
        int  n_rsp;
        bit  idle_seen;
        bit  reload;
        last_acc  = -1;
        n_acc     = 0;
        n_rsp     = 0;
        idle_seen = 1'b0;
        reload    = 1'b0;
        @(negedge pclk);
        bus.pready    = 1'b1;
        bus.pslverr   = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 10'h040;
        bus.cmd_strb  = 4'hF;
        bus.cmd_wdata = 32'h0;
        bus.cmd_prot  = 3'd0;
        for (int c = 0; c < 60 && n_rsp < 4; c++) begin
            if (c > 0) @(negedge pclk);
            if (bus.rsp_valid === 1'b1) begin
                sb_pop("b2b_rsp");
                n_rsp++;
            end
            if (bus.psel === 1'b0) idle_seen = 1'b1;
            bus.prdata = slave_data(bus.paddr);
            if (reload) begin
                reload = 1'b0;
                if (n_acc < 4) begin
                    bus.cmd_write = n_acc[0];
                    bus.cmd_addr  = 10'h040 + 10'(n_acc * 4);
                    bus.cmd_wdata = $urandom;
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (last_acc >= 0) begin
                    check("b2b_gap", c - last_acc, 4);
                    check("b2b_psel_gap", idle_seen, 1'b1);
                end
                idle_seen = 1'b0;
                last_acc  = c;
                exp_q.push_back({bus.cmd_write ? 32'h0 : slave_data(bus.cmd_addr), 1'b0, 1'b0});
                n_acc++;
                reload = 1'b1;
            end
        end
        check("b2b_accepts", n_acc, 4);
        check("b2b_responses", n_rsp, 4);
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.cmd_valid = 1'b0;
    endtask

    // driver: reset asserted while the transfer sits in ACCESS
    task automatic reset_mid_access();
        @(negedge pclk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 10'h0C0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge pclk);
        check("penable_before_reset", bus.penable, 1'b1);
        // pready offered at the reset edge must not produce a response
        preset      = 1'b1;
        bus.pready  = 1'b1;
        bus.prdata  = 32'hBAD0BAD0;
        bus.rsp_ready = 1'b1;
        @(negedge pclk);
        check("rst_psel", bus.psel, 1'b0);
        check("rst_penable", bus.penable, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("rst_state", bus.dbg_state, 2'd0);
        preset        = 1'b0;
        bus.pready    = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge pclk);
            check("post_rst_rsp_valid", bus.rsp_valid, 1'b0);
            check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
        end
        check("post_rst_queue", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 10'h010, 4'hF, 32'hDEADBEEF, 3'd0, 0,    32'h0,        1'b0, 0, 1,  32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b0, 10'h020, 4'hF, 32'hAAAA5555, 3'd2, 3,    32'h12345678, 1'b0, 0, 4,  32'h12345678, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 10'h3FC, 4'h5, 32'h01020304, 3'd1, 0,    32'hFFFFFFFF, 1'b1, 5, 1,  32'h0,        1'b1, 1'b0};
        vecs[3] = '{1'b0, 10'h100, 4'h0, 32'h0,        3'd0, 1000, 32'h0,        1'b0, 0, 16, 32'h0,        1'b1, 1'b1};
        vecs[4] = '{1'b0, 10'h104, 4'hF, 32'h0,        3'd0, 15,   32'hCAFEF00D, 1'b0, 2, 16, 32'hCAFEF00D, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 10'h2A8, 4'h0, 32'h0,        3'd5, 2,    32'h0BADF00D, 1'b1, 0, 3,  32'h0BADF00D, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 10'h0F0, 4'h3, 32'h11223344, 3'd7, 16,   32'h0,        1'b0, 1, 16, 32'h0,        1'b1, 1'b1};
        vecs[7] = '{1'b1, 10'h001, 4'h8, 32'h89ABCDEF, 3'd4, 1,    32'h55555555, 1'b0, 0, 2,  32'h0,        1'b0, 1'b0};

        preset        = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 10'h3FF;
        bus.cmd_strb  = 4'hF;
        bus.cmd_wdata = 32'hFFFFFFFF;
        bus.cmd_prot  = 3'd7;
        bus.rsp_ready = 1'b0;
        bus.prdata    = 32'h0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        repeat (3) @(negedge pclk);
        check("reset_cmd_ready", bus.cmd_ready, 1'b0);
        check("reset_psel", bus.psel, 1'b0);
        check("reset_penable", bus.penable, 1'b0);
        check("reset_apb_regs", {bus.pwrite, bus.paddr, bus.pstrb, bus.pwdata, bus.pprot}, 50'h0);
        check("reset_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}, 35'h0);
        check("reset_state", bus.dbg_state, 2'd0);
        preset        = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        check("idle_cmd_ready", bus.cmd_ready, 1'b1);

        for (int i = 0; i < 8; i++) run_xfer(vecs[i]);
        back_to_back();
        reset_mid_access();
        run_xfer(vecs[1]);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
